// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART command framer: command word layout,
// FSM state encodings and the saturating error-count helper.
package uart_frame_pkg;

    localparam int VALID_BIT = 15;
    localparam int SEL_BIT   = 14;
    localparam int DATA_MSB  = 13;
    localparam int DATA_LSB  = 6;
    localparam int ADDR_MSB  = 5;
    localparam int ADDR_LSB  = 1;
    localparam int WR_BIT    = 0;

    typedef enum logic {
        R_IDLE,
        R_HI
    } rx_state_e;

    typedef enum logic [2:0] {
        T_IDLE,
        T_HI,
        T_WAIT_HI,
        T_LO,
        T_WAIT_LO
    } tx_state_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_rsp_serializer.sv
// Return path: holds one 16-bit response and hands it to the UART
// transmitter as two bytes, high byte first.
module uart_rsp_serializer
    import uart_frame_pkg::*;
(
    input  logic        hclk,
    input  logic        hreset,
    input  logic [15:0] rsp_word,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_start,
    input  logic        tx_idle,
    input  logic        tx_done
);

    tx_state_e   state_q;
    logic [15:0] hold_q;
    logic [7:0]  tx_byte_q;
    logic        tx_start_q;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= T_IDLE;
            hold_q     <= 16'h0000;
            tx_byte_q  <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                T_IDLE: if (rsp_valid) begin
                    hold_q  <= rsp_word;
                    state_q <= T_HI;
                end
                T_HI: if (tx_idle) begin
                    tx_byte_q  <= hold_q[15:8];
                    tx_start_q <= 1'b1;
                    state_q    <= T_WAIT_HI;
                end
                T_WAIT_HI: if (tx_done) state_q <= T_LO;
                T_LO: if (tx_idle) begin
                    tx_byte_q  <= hold_q[7:0];
                    tx_start_q <= 1'b1;
                    state_q    <= T_WAIT_LO;
                end
                T_WAIT_LO: if (tx_done) state_q <= T_IDLE;
                default: state_q <= T_IDLE;
            endcase
        end
    end

    // Ready is a pure state decode, so it carries no path from any input.
    assign rsp_ready = (state_q == T_IDLE);
    assign tx_byte   = tx_byte_q;
    assign tx_start  = tx_start_q;

endmodule

// File: rtl/uart_cmd_framer.sv
// Byte framing between the UART and the AHB bridge: two-byte command
// assembly with inter-byte timeout, two-byte response serialisation.
module uart_cmd_framer
    import uart_frame_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_valid,
    output logic [15:0] cmd_word,
    output logic        cmd_strobe,
    input  logic [15:0] rsp_word,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_start,
    input  logic        tx_idle,
    input  logic        tx_done,
    output logic [7:0]  err_cnt
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    rx_state_e       rx_state_q;
    logic [7:0]      hi_q;
    logic [TO_W-1:0] to_q;
    logic [15:0]     cmd_word_q, cmd_word_d;
    logic            cmd_strobe_q;
    logic [7:0]      err_q;

    always_comb begin
        cmd_word_d                    = 16'h0000;
        cmd_word_d[VALID_BIT]         = hi_q[7];
        cmd_word_d[SEL_BIT]           = hi_q[6];
        cmd_word_d[DATA_MSB:DATA_LSB] = {hi_q[5:0], rx_byte[7:6]};
        cmd_word_d[ADDR_MSB:ADDR_LSB] = rx_byte[5:1];
        cmd_word_d[WR_BIT]            = rx_byte[0];
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            rx_state_q   <= R_IDLE;
            hi_q         <= 8'h00;
            to_q         <= '0;
            cmd_word_q   <= 16'h0000;
            cmd_strobe_q <= 1'b0;
            err_q        <= 8'h00;
        end else begin
            cmd_strobe_q <= 1'b0;
            case (rx_state_q)
                R_IDLE: if (rx_byte_valid) begin
                    if (rx_byte[7]) begin
                        hi_q       <= rx_byte;
                        to_q       <= '0;
                        rx_state_q <= R_HI;
                    end else begin
                        err_q <= sat_inc(err_q);
                    end
                end
                R_HI: begin
                    // A low byte wins over a timeout expiring in the same cycle.
                    if (rx_byte_valid) begin
                        cmd_word_q   <= cmd_word_d;
                        cmd_strobe_q <= 1'b1;
                        rx_state_q   <= R_IDLE;
                    end else if (to_q == TO_LAST) begin
                        err_q      <= sat_inc(err_q);
                        rx_state_q <= R_IDLE;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                default: rx_state_q <= R_IDLE;
            endcase
        end
    end

    assign cmd_word   = cmd_word_q;
    assign cmd_strobe = cmd_strobe_q;
    assign err_cnt    = err_q;

    uart_rsp_serializer u_rsp (
        .hclk      (hclk),
        .hreset    (hreset),
        .rsp_word  (rsp_word),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .tx_byte   (tx_byte),
        .tx_start  (tx_start),
        .tx_idle   (tx_idle),
        .tx_done   (tx_done)
    );

endmodule
